// File: rtl/router_pkg.sv
// router_pkg: shared constants and types for the 1x3 router slice.
//   DATA_W            FIFO data width.
//   LEN_MSB/LEN_LSB   header payload-length field.
//   ADDR_MSB          header address field is [ADDR_MSB:0].
//   SOFT_RST_TIMEOUT  router read-stall limit before a port soft reset.
//   MAX_RESP_DLY      largest legal destination response delay.
//   dest_state_e      destination reader FSM states.
package router_pkg;

   localparam int unsigned DATA_W           = 8;
   localparam int unsigned LEN_MSB          = 7;
   localparam int unsigned LEN_LSB          = 2;
   localparam int unsigned ADDR_MSB         = 1;
   localparam int unsigned SOFT_RST_TIMEOUT = 30;
   localparam int unsigned MAX_RESP_DLY     = SOFT_RST_TIMEOUT - 6;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_HDR_REQ,
      ST_HDR_WAIT,
      ST_BODY,
      ST_DONE
   } dest_state_e;

endpackage

// File: rtl/router_dest_reader.sv
// router_dest_reader: destination-side client for one router output port.
// Waits RESP_DLY cycles after vld_out, then drains one packet (header,
// L payload bytes, parity byte) from the port FIFO and checks parity.
//   clk, rst      clock, synchronous active-low reset
//   vld_out       FIFO non-empty
//   data_out      FIFO read data, valid the cycle after rd_en
//   soft_reset    router per-port soft reset (aborts packet, sets timeout_seen)
//   hold          stall, forces rd_en low
//   rd_en         registered FIFO read enable
//   busy          FSM out of IDLE
//   pkt_hdr       captured header byte
//   byte_out      payload byte, qualified by byte_vld
//   pkt_done      1-cycle end-of-packet strobe, parity_err valid with it
//   timeout_seen  sticky soft-reset flag, cleared by rst only
module router_dest_reader #(
   parameter int unsigned DATA_W   = router_pkg::DATA_W,
   parameter int unsigned RESP_DLY = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              vld_out,
   input  logic [DATA_W-1:0] data_out,
   input  logic              soft_reset,
   input  logic              hold,
   output logic              rd_en,
   output logic              busy,
   output logic [DATA_W-1:0] pkt_hdr,
   output logic [DATA_W-1:0] byte_out,
   output logic              byte_vld,
   output logic              pkt_done,
   output logic              parity_err,
   output logic              timeout_seen
);

   import router_pkg::*;

   if (RESP_DLY > MAX_RESP_DLY) begin : g_bad_resp_dly
      $error("router_dest_reader: RESP_DLY out of range 0..24");
   end

   localparam logic [4:0] DLY_LAST = (RESP_DLY == 0) ? 5'd0 : 5'(RESP_DLY - 1);

   dest_state_e       state, state_nxt;
   logic [4:0]        dly_cnt, dly_nxt;
   logic [6:0]        issued, issued_nxt;
   logic [6:0]        recvd, recvd_nxt;
   logic [6:0]        total, total_nxt;
   logic [DATA_W-1:0] acc, acc_nxt;
   logic [DATA_W-1:0] hdr_nxt, byte_nxt;
   logic              rd_d;
   logic              rd_nxt, byte_vld_nxt, done_nxt, perr_nxt, tout_nxt;

   assign busy = (state != ST_IDLE);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state        <= ST_IDLE;
         dly_cnt      <= '0;
         issued       <= '0;
         recvd        <= '0;
         total        <= '0;
         acc          <= '0;
         rd_en        <= 1'b0;
         rd_d         <= 1'b0;
         pkt_hdr      <= '0;
         byte_out     <= '0;
         byte_vld     <= 1'b0;
         pkt_done     <= 1'b0;
         parity_err   <= 1'b0;
         timeout_seen <= 1'b0;
      end else begin
         state        <= state_nxt;
         dly_cnt      <= dly_nxt;
         issued       <= issued_nxt;
         recvd        <= recvd_nxt;
         total        <= total_nxt;
         acc          <= acc_nxt;
         rd_en        <= rd_nxt;
         rd_d         <= rd_en;
         pkt_hdr      <= hdr_nxt;
         byte_out     <= byte_nxt;
         byte_vld     <= byte_vld_nxt;
         pkt_done     <= done_nxt;
         parity_err   <= perr_nxt;
         timeout_seen <= tout_nxt;
      end
   end

   // rd_d marks the cycle in which data_out holds the byte requested by the
   // previous rd_en; every capture below is keyed on it.
   always_comb begin
      state_nxt    = state;
      dly_nxt      = dly_cnt;
      issued_nxt   = issued;
      recvd_nxt    = recvd;
      total_nxt    = total;
      acc_nxt      = acc;
      hdr_nxt      = pkt_hdr;
      byte_nxt     = byte_out;
      rd_nxt       = 1'b0;
      byte_vld_nxt = 1'b0;
      done_nxt     = 1'b0;
      perr_nxt     = 1'b0;
      tout_nxt     = timeout_seen | soft_reset;

      unique case (state)
         ST_IDLE: begin
            if (vld_out) begin
               dly_nxt   = '0;
               // With no delay the WAIT cycle is skipped so rd_en still
               // rises RESP_DLY+1 cycles after vld_out is seen.
               state_nxt = (RESP_DLY == 0) ? ST_HDR_REQ : ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (dly_cnt == DLY_LAST) state_nxt = ST_HDR_REQ;
            else                     dly_nxt   = dly_cnt + 5'd1;
         end
         ST_HDR_REQ: begin
            if (vld_out && !hold) begin
               rd_nxt    = 1'b1;
               state_nxt = ST_HDR_WAIT;
            end
         end
         ST_HDR_WAIT: begin
            if (rd_d) begin
               hdr_nxt    = data_out;
               acc_nxt    = data_out;
               total_nxt  = 7'(data_out[LEN_MSB:LEN_LSB]) + 7'd1;
               issued_nxt = '0;
               recvd_nxt  = '0;
               state_nxt  = ST_BODY;
            end
         end
         ST_BODY: begin
            if ((issued < total) && vld_out && !hold) begin
               rd_nxt     = 1'b1;
               issued_nxt = issued + 7'd1;
            end
            if (rd_d) begin
               recvd_nxt = recvd + 7'd1;
               if ((recvd + 7'd1) == total) begin
                  done_nxt  = 1'b1;
                  perr_nxt  = (acc != data_out);
                  state_nxt = ST_DONE;
               end else begin
                  acc_nxt      = acc ^ data_out;
                  byte_nxt     = data_out;
                  byte_vld_nxt = 1'b1;
               end
            end
         end
         ST_DONE: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase

      if (soft_reset && (state != ST_IDLE)) begin
         state_nxt    = ST_IDLE;
         rd_nxt       = 1'b0;
         byte_vld_nxt = 1'b0;
         done_nxt     = 1'b0;
         perr_nxt     = 1'b0;
      end
   end

endmodule

// File: tb/tb_router_dest_reader.sv
module tb_router_dest_reader;

   import router_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       vld_out;
   logic [7:0] data_out = '0;
   logic       soft_reset = 1'b0;
   logic       hold = 1'b0;
   logic       gap = 1'b0;
   logic       rd_en, busy, byte_vld, pkt_done, parity_err, timeout_seen;
   logic [7:0] pkt_hdr, byte_out;

   always #5 clk = ~clk;

   router_dest_reader #(.DATA_W(8), .RESP_DLY(4)) dut (
      .clk(clk), .rst(rst), .vld_out(vld_out), .data_out(data_out),
      .soft_reset(soft_reset), .hold(hold), .rd_en(rd_en), .busy(busy),
      .pkt_hdr(pkt_hdr), .byte_out(byte_out), .byte_vld(byte_vld),
      .pkt_done(pkt_done), .parity_err(parity_err), .timeout_seen(timeout_seen)
   );

   // FIFO model: written by the stimulus, read on rd_en, flushed on reset.
   logic [7:0]  mem [0:255];
   int unsigned wr_ptr = 0;
   int unsigned rd_ptr = 0;

   assign vld_out = (rd_ptr != wr_ptr) && !gap;

   always @(posedge clk) begin
      if (!rst || soft_reset) rd_ptr <= wr_ptr;
      else if (rd_en && (rd_ptr != wr_ptr)) begin
         data_out <= mem[rd_ptr[7:0]];
         rd_ptr   <= rd_ptr + 1;
      end
   end

   // Output monitor
   int unsigned rd_cnt = 0, got_n = 0, done_cnt = 0;
   logic [7:0]  got [0:255];
   logic        last_perr = 1'b0;
   logic [7:0]  last_hdr = '0;

   always @(negedge clk) begin
      if (rd_en) rd_cnt <= rd_cnt + 1;
      if (byte_vld) begin
         got[got_n[7:0]] <= byte_out;
         got_n           <= got_n + 1;
      end
      if (pkt_done) begin
         done_cnt  <= done_cnt + 1;
         last_perr <= parity_err;
         last_hdr  <= pkt_hdr;
      end
   end

   int unsigned n_checks = 0, n_fail = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic push(input logic [7:0] b);
      mem[wr_ptr[7:0]] = b;
      wr_ptr++;
   endtask

   task automatic wait_done(input int unsigned base);
      int unsigned k = 0;
      while (done_cnt == base && k < 300) begin
         @(negedge clk);
         k++;
      end
      repeat (3) @(negedge clk);
   endtask

   int unsigned rd0, g0, d0, n, gap_rd;

   initial begin
      repeat (3) @(negedge clk);
      check("reset_outs", {rd_en, busy, byte_vld, pkt_done, parity_err, timeout_seen}, 0);
      check("reset_hdr", pkt_hdr, 8'h00);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // 1: L=3, good parity, latency and pulse counts
      rd0 = rd_cnt; g0 = got_n; d0 = done_cnt;
      push(8'h0E); push(8'h11); push(8'h22); push(8'h33); push(8'h0E);
      n = 0;
      while (n < 40) begin
         @(posedge clk); #1;
         if (rd_en) break;
         n++;
      end
      check("first_rd_lat", n, 5);
      check("busy_in_pkt", busy, 1'b1);
      wait_done(d0);
      check("p1_rd_pulses", rd_cnt - rd0, 5);
      check("p1_nbytes", got_n - g0, 3);
      check("p1_b0", got[g0[7:0]], 8'h11);
      check("p1_b1", got[8'(g0 + 1)], 8'h22);
      check("p1_b2", got[8'(g0 + 2)], 8'h33);
      check("p1_done", done_cnt - d0, 1);
      check("p1_perr", last_perr, 1'b0);
      check("p1_idle", busy, 1'b0);

      // 2: same packet, bad parity
      rd0 = rd_cnt; g0 = got_n; d0 = done_cnt;
      push(8'h0E); push(8'h11); push(8'h22); push(8'h33); push(8'h0F);
      wait_done(d0);
      check("p2_done", done_cnt - d0, 1);
      check("p2_perr", last_perr, 1'b1);
      check("p2_hdr", last_hdr, 8'h0E);
      check("p2_nbytes", got_n - g0, 3);

      // 3: L=0
      rd0 = rd_cnt; g0 = got_n; d0 = done_cnt;
      push(8'h00); push(8'h00);
      wait_done(d0);
      check("p3_rd_pulses", rd_cnt - rd0, 2);
      check("p3_nbytes", got_n - g0, 0);
      check("p3_done", done_cnt - d0, 1);
      check("p3_perr", last_perr, 1'b0);

      // 4: vld_out gap after 2 payload bytes
      rd0 = rd_cnt; g0 = got_n; d0 = done_cnt;
      push(8'h0E); push(8'h11); push(8'h22); push(8'h33); push(8'h0E);
      n = 0;
      while ((got_n - g0) < 2 && n < 100) begin @(negedge clk); n++; end
      check("p4_reach_gap", got_n - g0, 2);
      gap = 1'b1;
      gap_rd = 0;
      repeat (5) begin
         @(negedge clk);
         if (rd_en) gap_rd++;
      end
      check("p4_gap_rd", gap_rd, 0);
      gap = 1'b0;
      wait_done(d0);
      check("p4_done", done_cnt - d0, 1);
      check("p4_perr", last_perr, 1'b0);
      check("p4_rd_pulses", rd_cnt - rd0, 5);
      check("p4_b2", got[8'(g0 + 2)], 8'h33);

      // 5: hold stall aborted by soft_reset
      rd0 = rd_cnt; d0 = done_cnt;
      check("p5_tout_pre", timeout_seen, 1'b0);
      push(8'h0E); push(8'h11); push(8'h22); push(8'h33); push(8'h0E);
      n = 0;
      while ((rd_cnt - rd0) < 2 && n < 100) begin @(negedge clk); n++; end
      hold = 1'b1;
      repeat (SOFT_RST_TIMEOUT) @(negedge clk);
      check("p5_stalled_busy", busy, 1'b1);
      check("p5_stalled_rd", rd_en, 1'b0);
      soft_reset = 1'b1;
      @(posedge clk); #1;
      check("p5_abort_outs", {busy, rd_en, byte_vld, pkt_done}, 0);
      check("p5_abort_state", 32'(dut.state), 32'(ST_IDLE));
      check("p5_tout", timeout_seen, 1'b1);
      @(negedge clk);
      soft_reset = 1'b0;
      hold = 1'b0;
      repeat (5) @(negedge clk);
      check("p5_no_done", done_cnt - d0, 0);
      check("p5_tout_sticky", timeout_seen, 1'b1);
      check("p5_stay_idle", busy, 1'b0);

      // 6: rst mid-BODY, then a fresh packet
      g0 = got_n;
      push(8'h0E); push(8'h11); push(8'h22); push(8'h33); push(8'h0E);
      n = 0;
      while ((got_n - g0) < 1 && n < 100) begin @(negedge clk); n++; end
      rst = 1'b0;
      @(posedge clk); #1;
      check("p6_rst_outs", {rd_en, busy, byte_vld, pkt_done, parity_err, timeout_seen}, 0);
      check("p6_rst_data", {pkt_hdr, byte_out}, 0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rd0 = rd_cnt; g0 = got_n; d0 = done_cnt;
      push(8'h09); push(8'hA5); push(8'h5A); push(8'hF6);
      wait_done(d0);
      check("p6_done", done_cnt - d0, 1);
      check("p6_perr", last_perr, 1'b0);
      check("p6_hdr", last_hdr, 8'h09);
      check("p6_nbytes", got_n - g0, 2);
      check("p6_b0", got[g0[7:0]], 8'hA5);
      check("p6_b1", got[8'(g0 + 1)], 8'h5A);
      check("p6_rd_pulses", rd_cnt - rd0, 4);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
